// File: rtl/page_table_responder_if.sv
// Lookup/complete bus plus table write port between a TLB miss path and
// the page-table responder.
//
// Handshake: the master raises LOOKUP_RQST (a level) with LOOKUP_ADDR and keeps
// it up until it is taken. It is taken only at an edge where LOOKUP_BUSY=0.
// LOOKUP_COMPLETE is a one-cycle pulse that marks LOOKUP_RETURN/LOOKUP_FAULT
// as valid. There is no back-pressure on the response. WR_EN is a
// single-cycle strobe that the responder takes at any edge.
interface page_table_responder_if #(
  parameter int ADDR_W  = 6,
  parameter int TRANS_W = 12
);
  logic               LOOKUP_RQST;
  logic [ADDR_W-1:0]  LOOKUP_ADDR;
  logic               LOOKUP_COMPLETE;
  logic [TRANS_W-1:0] LOOKUP_RETURN;
  logic               LOOKUP_FAULT;
  logic               LOOKUP_BUSY;
  logic               WR_EN;
  logic [ADDR_W-1:0]  WR_ADDR;
  logic [TRANS_W-1:0] WR_DATA;
  logic               WR_VALID;

  modport master (
    output LOOKUP_RQST, LOOKUP_ADDR, WR_EN, WR_ADDR, WR_DATA, WR_VALID,
    input  LOOKUP_COMPLETE, LOOKUP_RETURN, LOOKUP_FAULT, LOOKUP_BUSY
  );

  modport slave (
    input  LOOKUP_RQST, LOOKUP_ADDR, WR_EN, WR_ADDR, WR_DATA, WR_VALID,
    output LOOKUP_COMPLETE, LOOKUP_RETURN, LOOKUP_FAULT, LOOKUP_BUSY
  );
endinterface

// File: rtl/page_table_responder.sv
// Single-level page table that acts as the TLB miss handler. It returns a
// translation, or a fault, after a fixed walk latency.
module page_table_responder #(
  parameter int ADDR_W   = 6,
  parameter int TRANS_W  = 12,
  parameter int WALK_LAT = 4   // legal range 1..15
) (
  input  logic                   clk,
  input  logic                   rst,
  page_table_responder_if.slave  bus,
  output logic [1:0]             dbg_state_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(WALK_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               complete_q, complete_d;
  logic [TRANS_W-1:0] ret_q, ret_d;
  logic               fault_q, fault_d;

  logic [DEPTH-1:0]   valid_q;
  logic [TRANS_W-1:0] data_q [DEPTH];

  // Valid bits are reset and data is not, so an entry that was never written reads as a fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (bus.WR_EN) begin
      valid_q[bus.WR_ADDR] <= bus.WR_VALID;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.WR_EN) begin
      data_q[bus.WR_ADDR] <= bus.WR_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      complete_q <= 1'b0;
      ret_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      complete_q <= complete_d;
      ret_q      <= ret_d;
      fault_q    <= fault_d;
    end
  end

  // The final walk read samples the stored entry at the edge where a same-edge write
  // also commits, so that write is not seen (read-before-write).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    complete_d = 1'b0;
    ret_d      = ret_q;
    fault_d    = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.LOOKUP_RQST) begin
          addr_d  = bus.LOOKUP_ADDR;
          cnt_d   = LAT_M1;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (cnt_q == 4'd0) begin
          ret_d      = valid_q[addr_q] ? data_q[addr_q] : '0;
          fault_d    = ~valid_q[addr_q];
          complete_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.LOOKUP_COMPLETE = complete_q;
  assign bus.LOOKUP_RETURN   = ret_q;
  assign bus.LOOKUP_FAULT    = fault_q;
  assign bus.LOOKUP_BUSY     = (state_q != S_IDLE);
  assign dbg_state_o         = state_q;
endmodule
